cla_share_arbiter: RTL and testbench

Round-robin scheduler that shares one `carry_lookahead_adder` instance between N_REQ requesters in the PE datapath, such as the Wallace final-stage add and the accumulator update. Each requester uses a valid/ready operand channel and a valid/ready result channel. The block grants one requester at a time, registers its operands, runs the adder for one cycle and holds the registered sum, including carry-out, until the owner accepts it.

---
 rtl/cla_share_pkg.sv | 15 +
 rtl/carry_lookahead_adder.sv | 42 ++++
 rtl/cla_share_arbiter_rr_arbiter.sv | 33 +++
 rtl/cla_share_arbiter.sv | 120 ++++++++++++
 tb/tb_cla_share_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cla_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
package cla_share_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESP    = 2'd2
   } state_e;

   // Index width for n requesters; never below one bit so ports stay legal.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned adder built from 4-bit carry-lookahead groups chained group to group.
module carry_lookahead_adder #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);
   localparam int unsigned NG = WIDTH / 4;

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [NG:0]      c_grp;

   assign p        = A ^ B;
   assign g        = A & B;
   assign c_grp[0] = Cin;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] pp;
      logic [3:0] gg;
      logic [4:0] cc;

      assign pp    = p[gi*4 +: 4];
      assign gg    = g[gi*4 +: 4];
      assign cc[0] = c_grp[gi];
      assign cc[1] = gg[0] | (pp[0] & cc[0]);
      assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
      assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & cc[0]);
      assign cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cc[0]);

      assign Sum[gi*4 +: 4] = pp ^ cc[3:0];
      assign c_grp[gi+1]    = cc[4];
   end

   assign Cout = c_grp[NG];

endmodule

// File: rtl/cla_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter
   import cla_share_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]             req,
   input  logic [id_width(N)-1:0]   ptr,
   input  logic                     en,
   output logic [N-1:0]             grant,
   output logic [id_width(N)-1:0]   idx
);
   localparam int unsigned IW = id_width(N);

   logic        found;
   int unsigned j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (en && !found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/cla_share_arbiter.sv
// Shares one carry-lookahead adder among N_REQ requesters with round-robin grants.
// One transaction in flight: IDLE grants, COMPUTE registers the sum, RESP holds it for the owner.
module cla_share_arbiter
   import cla_share_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N_REQ = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*WIDTH-1:0]        req_a,
   input  logic [N_REQ*WIDTH-1:0]        req_b,
   output logic [N_REQ-1:0]              req_ready,
   output logic [N_REQ-1:0]              rsp_valid,
   input  logic [N_REQ-1:0]              rsp_ready,
   output logic [WIDTH:0]                rsp_sum,
   output logic [id_width(N_REQ)-1:0]    rsp_id,
   output logic                          busy
);
   localparam int unsigned ID_W = id_width(N_REQ);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d;
   logic [WIDTH-1:0]  op_b_q, op_b_d;
   logic [WIDTH:0]    sum_q, sum_d;
   logic [ID_W-1:0]   id_q, id_d;

   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   gidx;
   logic              arb_en;
   logic [WIDTH-1:0]  add_sum;
   logic              add_cout;

   // Gating with rst_n keeps req_ready low for the whole reset window.
   assign arb_en = (state_q == IDLE) && rst_n;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .en    (arb_en),
      .grant (grant),
      .idx   (gidx)
   );

   carry_lookahead_adder #(
      .WIDTH (WIDTH)
   ) u_add (
      .A    (op_a_q),
      .B    (op_b_q),
      .Cin  (1'b0),
      .Sum  (add_sum),
      .Cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      id_d    = id_q;
      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               op_a_d  = req_a[32'(gidx)*WIDTH +: WIDTH];
               op_b_d  = req_b[32'(gidx)*WIDTH +: WIDTH];
               owner_d = gidx;
               ptr_d   = (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            sum_d   = {add_cout, add_sum};
            id_d    = owner_q;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
   end

   assign req_ready = grant;
   assign rsp_sum   = sum_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed bench for cla_share_arbiter: reset, carry-out, backpressure, reset in flight, round robin.
module tb_cla_share_arbiter;
   localparam int unsigned W = 64;
   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [W:0]     rsp_sum;
   logic [1:0]     rsp_id;
   logic           busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_share_arbiter #(
      .WIDTH (W),
      .N_REQ (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [W-1:0] rr_a(input int unsigned i, input int unsigned r);
      return 64'hF000_0000_0000_0000 + 64'(i * 16 + r);
   endfunction

   function automatic logic [W-1:0] rr_b(input int unsigned i, input int unsigned r);
      return 64'h1000_0000_0000_0000 * 64'(i + 1) + 64'(r);
   endfunction

   // Expects requester g to be granted now, then follows it through COMPUTE and RESP.
   task automatic serve(input int unsigned g, input logic [W:0] exp, input string tag);
      logic [N-1:0] oh;
      oh    = '0;
      oh[g] = 1'b1;
      #1;
      chk({tag, " req_ready"}, (W+1)'(req_ready), (W+1)'(oh));
      cyc();
      chk({tag, " busy_compute"}, (W+1)'(busy), (W+1)'(1));
      chk({tag, " req_ready_compute"}, (W+1)'(req_ready), '0);
      chk({tag, " rsp_valid_compute"}, (W+1)'(rsp_valid), '0);
      cyc();
      chk({tag, " rsp_valid"}, (W+1)'(rsp_valid), (W+1)'(oh));
      chk({tag, " rsp_sum"}, rsp_sum, exp);
      chk({tag, " rsp_id"}, (W+1)'(rsp_id), (W+1)'(g));
      rsp_ready = oh;
      cyc();
      rsp_ready = '0;
      chk({tag, " rsp_valid_after"}, (W+1)'(rsp_valid), '0);
      chk({tag, " busy_after"}, (W+1)'(busy), '0);
      chk({tag, " rsp_sum_hold"}, rsp_sum, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      cyc();
      chk("reset req_ready", (W+1)'(req_ready), '0);
      chk("reset rsp_valid", (W+1)'(rsp_valid), '0);
      chk("reset busy", (W+1)'(busy), '0);
      chk("reset rsp_sum", rsp_sum, '0);
      chk("reset rsp_id", (W+1)'(rsp_id), '0);
      cyc();

      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      set_req(2, 64'd5, 64'd7);
      serve(2, 65'd12, "first");
      req_valid[2] = 1'b0;

      // ptr=3: scan 3,0,1
      set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      serve(1, 65'h1_0000_0000_0000_0000, "carry_ones");
      req_valid[1] = 1'b0;

      // ptr=2: scan 2,3,0
      set_req(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      serve(0, 65'h1_0000_0000_0000_0000, "carry_msb");
      req_valid[0] = 1'b0;

      // ptr=1: requesters 2 and 3 pending, 2 wins; owner stalls while others press rsp_ready
      set_req(2, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
      set_req(3, 64'd100, 64'd200);
      #1;
      chk("bp req_ready", (W+1)'(req_ready), (W+1)'(4'b0100));
      cyc();
      req_valid[2] = 1'b0;
      cyc();
      rsp_ready = 4'b1011;
      for (int unsigned k = 0; k < 5; k++) begin
         chk("bp rsp_valid", (W+1)'(rsp_valid), (W+1)'(4'b0100));
         chk("bp rsp_sum", rsp_sum, 65'h0_1234_5678_9ABC_DF00);
         chk("bp req_ready", (W+1)'(req_ready), '0);
         cyc();
      end
      rsp_ready = 4'b0100;
      cyc();
      rsp_ready = '0;
      chk("bp released", (W+1)'(rsp_valid), '0);
      serve(3, 65'd300, "bp_pending");
      req_valid[3] = 1'b0;

      // ptr=0: grant 1 moves ptr to 2, then reset lands in COMPUTE
      set_req(1, 64'd1, 64'd2);
      set_req(2, 64'd40, 64'd2);
      #1;
      chk("flight req_ready", (W+1)'(req_ready), (W+1)'(4'b0010));
      cyc();
      chk("flight busy", (W+1)'(busy), (W+1)'(1));
      rst_n = 1'b0;
      #1;
      chk("flight rst busy", (W+1)'(busy), '0);
      chk("flight rst rsp_valid", (W+1)'(rsp_valid), '0);
      chk("flight rst req_ready", (W+1)'(req_ready), '0);
      chk("flight rst rsp_sum", rsp_sum, '0);
      cyc();
      chk("flight rst hold rsp_valid", (W+1)'(rsp_valid), '0);
      rst_n = 1'b1;
      serve(1, 65'd3, "after_rst");
      req_valid[1] = 1'b0;
      serve(2, 65'd42, "after_rst_next");
      req_valid[2] = 1'b0;

      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int unsigned i = 0; i < N; i++) set_req(i, rr_a(i, 0), rr_b(i, 0));
      for (int unsigned k = 0; k < 5; k++) begin
         int unsigned g;
         int unsigned r;
         g = k % N;
         r = k / N;
         serve(g, ref_add(rr_a(g, r), rr_b(g, r)), "rr");
         set_req(g, rr_a(g, r + 1), rr_b(g, r + 1));
      end
      req_valid = '0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
